// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO access arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_arb_pkg;

    // Controller modes: normal arbitration, draining reads, read retirement wait
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FLUSH      = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } state_t;

    // Cycles between the last drain read being issued and the done pulse
    localparam int FLUSH_WAIT_CYCLES = 2;

    // Occupancy counter width: must be able to hold the value FIFO_DEPTH itself
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_access_arbiter_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr wins, next ptr follows winner.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the grant is used.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      next_ptr
);

    logic found;
    int   idx;

    // Scan requesters starting at ptr, wrapping, and pick the first one set
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = PW'((idx + 1) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_access_arbiter.sv
// Shares one FIFO between NUM_REQ round-robin producers and one consumer, with flush/drain.
// Latency: write lands in FIFO one cycle after handshake; read data valid two cycles after RD_ACK.
// Backpressure: REQ_READY/RD_ACK gated by the local LEVEL count; macro FIFO_ARB_RD_PRIO_EN makes reads win conflicts.
module fifo_access_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                  CLK,
    input  logic                                  RST_N,
    input  logic [NUM_REQ-1:0]                    REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         REQ_DATA,
    output logic [NUM_REQ-1:0]                    REQ_READY,
    input  logic                                  RD_REQ,
    output logic                                  RD_ACK,
    output logic                                  RD_VALID,
    output logic [DATA_WIDTH-1:0]                 RD_DATA,
    input  logic                                  FLUSH,
    output logic                                  FLUSH_DONE,
    output logic [level_width(FIFO_DEPTH)-1:0]    LEVEL,
    output logic                                  FIFO_WR_EN,
    output logic                                  FIFO_RD_EN,
    output logic [DATA_WIDTH-1:0]                 FIFO_DIN,
    input  logic [DATA_WIDTH-1:0]                 FIFO_DOUT
);

    localparam int LW = level_width(FIFO_DEPTH);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [1:0]    WAIT_LAST = 2'(FLUSH_WAIT_CYCLES - 1);

    state_t                state;
    logic [PW-1:0]         rr_ptr;
    logic [1:0]            wait_cnt;
    logic [NUM_REQ-1:0]    arb_grant;
    logic [PW-1:0]         arb_next_ptr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  wr_cand;
    logic                  rd_cand;
    logic                  do_wr;
    logic                  do_rd;
    logic                  flush_rd;
`ifndef FIFO_ARB_RD_PRIO_EN
    logic                  toggle;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr (
        .req      (REQ_VALID),
        .ptr      (rr_ptr),
        .grant    (arb_grant),
        .next_ptr (arb_next_ptr)
    );

    // The FIFO's DOUT is already registered, so read data passes straight through
    assign RD_DATA = FIFO_DOUT;

    // Candidate detection and conflict resolution; the FIFO drops cycles with both enables high
    always_comb begin
        wr_cand  = (state == ST_RUN) && (|REQ_VALID) && (LEVEL < DEPTH_L);
        rd_cand  = (state == ST_RUN) && RD_REQ && (LEVEL != '0);
        flush_rd = (state == ST_FLUSH) && (LEVEL != '0);
`ifdef FIFO_ARB_RD_PRIO_EN
        do_wr = wr_cand && !rd_cand;
        do_rd = rd_cand;
`else
        do_wr = wr_cand && (!rd_cand || !toggle);
        do_rd = rd_cand && (!wr_cand || toggle);
`endif
        // Handshakes are forced low while reset is held, regardless of inputs
        REQ_READY = (do_wr && RST_N) ? arb_grant : '0;
        RD_ACK    = do_rd && RST_N;
    end

    // Select the granted producer's data word
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Controller state, occupancy, round-robin pointer and registered FIFO controls
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_RUN;
            rr_ptr     <= '0;
            LEVEL      <= '0;
            wait_cnt   <= '0;
            FIFO_WR_EN <= 1'b0;
            FIFO_RD_EN <= 1'b0;
            FIFO_DIN   <= '0;
            RD_VALID   <= 1'b0;
            FLUSH_DONE <= 1'b0;
`ifndef FIFO_ARB_RD_PRIO_EN
            toggle     <= 1'b0;
`endif
        end else begin
            FIFO_WR_EN <= do_wr;
            FIFO_RD_EN <= do_rd || flush_rd;
            RD_VALID   <= FIFO_RD_EN;
            FLUSH_DONE <= 1'b0;
            if (do_wr) begin
                FIFO_DIN <= sel_data;
                rr_ptr   <= arb_next_ptr;
                LEVEL    <= LEVEL + LW'(1);
            end else if (do_rd || flush_rd) begin
                LEVEL    <= LEVEL - LW'(1);
            end
`ifndef FIFO_ARB_RD_PRIO_EN
            if (wr_cand && rd_cand) begin
                toggle <= ~toggle;
            end
`endif
            case (state)
                ST_RUN: begin
                    if (FLUSH) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // Leave as the final drain read is issued (or at once if already empty)
                    if (LEVEL <= LW'(1)) begin
                        state    <= ST_FLUSH_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_FLUSH_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state      <= ST_RUN;
                        FLUSH_DONE <= 1'b1;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
